// File: rtl/joy_pkg.sv
// ---------------------------------------------------------------------------
// joy_pkg
// Shared definitions for the joystick serializer and for any receiver that
// has to unpack its frames:
//   JOY_FRAME_BITS   - bits carried by one frame (two 12-bit joysticks)
//   joy_state_t      - serializer state enumeration
//   joy_src_t        - one entry of the frame bit-order table
//   joyFrameSrc()    - frame index -> (joystick, bit) lookup
//   joyBuildFrame()  - packs both joysticks into a frame, index 0 in bit 0
// ---------------------------------------------------------------------------
package joy_pkg;

   localparam int JOY_FRAME_BITS = 24;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } joy_state_t;

   typedef struct packed {
      logic       player2;
      logic [3:0] bitIdx;
   } joy_src_t;

   // Joystick bit numbers in the order they leave the serializer. Entry 0
   // sits in the lowest nibble. Positions 0-7 carry the first eight bits of
   // a player, positions 8-11 carry that player's remaining four bits.
   localparam logic [47:0] JOY_BIT_ORDER = {
      4'd7, 4'd9, 4'd11, 4'd10,
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8
   };

   // Frame layout: player 1 low group, player 2 low group, then the high
   // groups in the opposite player order (player 2 first, player 1 last).
   function automatic joy_src_t joyFrameSrc(input int unsigned idx);
      joy_src_t    src;
      int unsigned pos;
      pos         = (idx < 16) ? (idx % 8) : (8 + (idx % 4));
      src.player2 = (idx >= 8) && (idx < 20);
      src.bitIdx  = JOY_BIT_ORDER[pos*4 +: 4];
      return src;
   endfunction

   // Walks the bit-order table so frame bit i is the control sent i-th.
   function automatic logic [JOY_FRAME_BITS-1:0] joyBuildFrame(input logic [11:0] j1,
                                                               input logic [11:0] j2);
      logic [JOY_FRAME_BITS-1:0] frame;
      joy_src_t                  src;
      for (int i = 0; i < JOY_FRAME_BITS; i++) begin
         src      = joyFrameSrc(i);
         frame[i] = src.player2 ? j2[src.bitIdx] : j1[src.bitIdx];
      end
      return frame;
   endfunction

endpackage

// File: rtl/joy_serializer_if.sv
// ---------------------------------------------------------------------------
// joy_serializer_if
// Groups the joystick inputs, reader pins and status outputs.
//   joystick1/2 - active-low controls, 12 bits each
//   JOY_CLK     - shift clock from the reader (asynchronous)
//   JOY_LOAD    - active-low parallel-load strobe from the reader
//   JOY_DATA    - serial data back to the reader
//   busy        - frame is being shifted
//   frame_done  - one-cycle pulse after the final bit
// master: the side driving controls and reader pins; slave: the serializer.
// ---------------------------------------------------------------------------
interface joy_serializer_if;

   logic [11:0] joystick1;
   logic [11:0] joystick2;
   logic        JOY_CLK;
   logic        JOY_LOAD;
   logic        JOY_DATA;
   logic        busy;
   logic        frame_done;

   modport master (
      output joystick1, joystick2, JOY_CLK, JOY_LOAD,
      input  JOY_DATA, busy, frame_done
   );

   modport slave (
      input  joystick1, joystick2, JOY_CLK, JOY_LOAD,
      output JOY_DATA, busy, frame_done
   );

endinterface

// File: rtl/joy_sync.sv
// ---------------------------------------------------------------------------
// joy_sync
// Multi-stage synchronizer for one asynchronous pin plus a rising-edge
// detector on the synchronized level. All stages reset to 1 so an idle-high
// pin produces no spurious edge after reset.
//   clk_i   - system clock
//   reset_i - synchronous active-high reset
//   async_i - asynchronous pin
//   sync_o  - synchronized level
//   rise_o  - one-cycle pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module joy_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o
);

   logic [STAGES-1:0] syncChain_q;
   logic              prev_q;

   // Shift the pin through the chain; prev_q keeps the last synchronized
   // level so a rise can be seen without adding another stage of latency.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         syncChain_q <= '1;
         prev_q      <= 1'b1;
      end else begin
         syncChain_q[0] <= async_i;
         for (int i = 1; i < STAGES; i++) begin
            syncChain_q[i] <= syncChain_q[i-1];
         end
         prev_q <= syncChain_q[STAGES-1];
      end
   end

   assign sync_o = syncChain_q[STAGES-1];
   assign rise_o = syncChain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/joy_serializer.sv
// ---------------------------------------------------------------------------
// joy_serializer
// Serializes two 12-bit active-low joysticks onto a shift-register style
// reader interface (JOY_LOAD strobe + JOY_CLK shift clock).
//   clk_sys - system clock, at least 8x faster than JOY_CLK
//   reset   - synchronous active-high reset
//   joy     - joy_serializer_if.slave: joysticks in, reader pins,
//             JOY_DATA / busy / frame_done out
// Parameters: FRAME_BITS (bits per frame), SYNC_STAGES (pin synchronizer depth)
// Optional feature: define JOY_STICKY_PRESS_EN to latch any press seen
// between loads so short taps still reach the reader.
// ---------------------------------------------------------------------------
module joy_serializer #(
   parameter int FRAME_BITS  = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_sys,
   input  logic             reset,
   joy_serializer_if.slave  joy
);

   import joy_pkg::*;

   localparam int CNT_W = $clog2(FRAME_BITS + 1);

   joy_state_t                state_q, state_d;
   logic [JOY_FRAME_BITS-1:0] shiftReg_q, shiftReg_d;
   logic [CNT_W-1:0]          bitCnt_q, bitCnt_d;
   logic                      data_q, data_d;
   logic                      frameDone_q, frameDone_d;
   logic                      busyO;

   logic                      clkRise, unusedClkLevel;
   logic                      loadSync, unusedLoadRise;
   logic [11:0]               loadJ1, loadJ2;
   logic [JOY_FRAME_BITS-1:0] loadFrame;

   // Only the shift clock's edge and the load strobe's level matter.
   joy_sync #(.STAGES(SYNC_STAGES)) uClkSync (
      .clk_i   (clk_sys),
      .reset_i (reset),
      .async_i (joy.JOY_CLK),
      .sync_o  (unusedClkLevel),
      .rise_o  (clkRise)
   );

   joy_sync #(.STAGES(SYNC_STAGES)) uLoadSync (
      .clk_i   (clk_sys),
      .reset_i (reset),
      .async_i (joy.JOY_LOAD),
      .sync_o  (loadSync),
      .rise_o  (unusedLoadRise)
   );

`ifdef JOY_STICKY_PRESS_EN
   logic [23:0] sticky_q, sticky_d;

   // Any control seen low since the last load stays low here until the
   // reader releases the strobe and shifting begins.
   always_comb begin
      sticky_d = sticky_q & {joy.joystick2, joy.joystick1};
      if (state_q == LOAD && state_d == SHIFT) begin
         sticky_d = '1;
      end
   end

   // Sticky capture register, released to all-ones by reset.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sticky_q <= '1;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign loadJ1 = joy.joystick1 & sticky_q[11:0];
   assign loadJ2 = joy.joystick2 & sticky_q[23:12];
`else
   assign loadJ1 = joy.joystick1;
   assign loadJ2 = joy.joystick2;
`endif

   assign loadFrame = joyBuildFrame(loadJ1, loadJ2);

   // State and datapath registers. JOY_DATA is registered from next-state
   // values so it moves on the same edge as the state it belongs to.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= IDLE;
         shiftReg_q  <= '1;
         bitCnt_q    <= '0;
         data_q      <= 1'b1;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shiftReg_q  <= shiftReg_d;
         bitCnt_q    <= bitCnt_d;
         data_q      <= data_d;
         frameDone_q <= frameDone_d;
      end
   end

   // Next-state logic. A low strobe wins over everything else: it forces a
   // (re)load from any state, so shift-clock rises during it are ignored and
   // a running frame is abandoned. Shifting fills with ones so bits past the
   // table read as idle. The count stops at FRAME_BITS because DONE never
   // advances it.
   always_comb begin
      state_d    = state_q;
      shiftReg_d = shiftReg_q;
      bitCnt_d   = bitCnt_q;
      if (!loadSync) begin
         state_d    = LOAD;
         shiftReg_d = loadFrame;
         bitCnt_d   = '0;
      end else begin
         case (state_q)
            LOAD: begin
               state_d    = SHIFT;
               shiftReg_d = loadFrame;
               bitCnt_d   = '0;
            end
            SHIFT: begin
               if (clkRise) begin
                  shiftReg_d = {1'b1, shiftReg_q[JOY_FRAME_BITS-1:1]};
                  bitCnt_d   = bitCnt_q + CNT_W'(1);
                  if (bitCnt_q + CNT_W'(1) == CNT_W'(FRAME_BITS)) begin
                     state_d = DONE;
                  end
               end
            end
            IDLE, DONE: begin
               state_d = state_q;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs: idle fill of 1 outside LOAD/SHIFT, frame_done only on a
   // completed frame (an aborted frame goes SHIFT->LOAD instead).
   always_comb begin
      data_d = 1'b1;
      if (state_d == LOAD || state_d == SHIFT) begin
         data_d = shiftReg_d[0];
      end
      frameDone_d = (state_q == SHIFT) && (state_d == DONE);
      busyO       = (state_q == SHIFT);
   end

   assign joy.JOY_DATA   = data_q;
   assign joy.busy       = busyO;
   assign joy.frame_done = frameDone_q;

endmodule

// File: tb/tb_joy_serializer.sv
// ---------------------------------------------------------------------------
// tb_joy_serializer
// Self-checking bench for joy_serializer. Acts as the reader: pulses
// JOY_LOAD / JOY_CLK slowly relative to clk_sys and compares JOY_DATA against
// a queue of expected bits built from hand-derived frame constants.
// Sticky-press checks are built only when JOY_STICKY_PRESS_EN is defined.
// ---------------------------------------------------------------------------
module tb_joy_serializer;

   localparam int FRAME = 24;

   typedef struct packed {
      logic [11:0] j1;
      logic [11:0] j2;
      logic [23:0] expFrame;
      logic [7:0]  nRises;
   } vec_t;

   logic clk_sys = 1'b0;
   logic reset;
   int   checks    = 0;
   int   failures  = 0;
   int   doneCount = 0;
   logic expQ[$];
   vec_t vecs[8];

   joy_serializer_if ifc();

   joy_serializer #(.FRAME_BITS(FRAME), .SYNC_STAGES(2)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .joy     (ifc)
   );

   // 100 MHz system clock
   always #5 clk_sys = ~clk_sys;

   // Count frame_done pulses away from the active edge
   always @(negedge clk_sys) begin
      if (ifc.frame_done === 1'b1) doneCount++;
   end

   // Generic comparison with failure report
   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Pop the next expected serial bit and compare it with JOY_DATA
   task automatic checkOutput(input string name);
      logic expBit;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: actual=%0b expected=<scoreboard empty>", name, ifc.JOY_DATA);
      end else begin
         expBit = expQ.pop_front();
         checkVal(name, 32'(ifc.JOY_DATA), 32'(expBit));
      end
   endtask

   // One JOY_CLK period of 8 system clocks, starting and ending on a negedge
   task automatic pulseClk();
      ifc.JOY_CLK = 1'b1;
      repeat (4) @(negedge clk_sys);
      ifc.JOY_CLK = 1'b0;
      repeat (4) @(negedge clk_sys);
   endtask

   // Counts system clocks from a pin change until JOY_DATA reaches target
   task automatic measureLatency(input string name, input logic target);
      int  n    = 0;
      bit  seen = 1'b0;
      for (int i = 1; i <= 16 && !seen; i++) begin
         @(negedge clk_sys);
         if (ifc.JOY_DATA === target) begin
            seen = 1'b1;
            n    = i;
         end
      end
      checkVal(name, 32'(n), 32'd3);
   endtask

   // Load (with a clock rise during the strobe, which must be ignored), then
   // shift nRises bits, checking every presented bit via the scoreboard
   task automatic runLoadedFrame(input logic [23:0] expFrame, input int nRises, input string name);
      int doneBefore;
      doneBefore = doneCount;
      expQ.delete();
      for (int i = 0; i < FRAME; i++) expQ.push_back(expFrame[i]);
      for (int i = FRAME; i <= nRises; i++) expQ.push_back(1'b1);
      ifc.JOY_LOAD = 1'b0;
      repeat (4) @(negedge clk_sys);
      pulseClk();
      checkVal({name, "_load_data"}, 32'(ifc.JOY_DATA), 32'(expFrame[0]));
      checkVal({name, "_load_busy"}, 32'(ifc.busy), 32'd0);
      ifc.JOY_LOAD = 1'b1;
      repeat (4) @(negedge clk_sys);
      checkVal({name, "_busy_start"}, 32'(ifc.busy), 32'd1);
      checkOutput({name, "_bit0"});
      for (int r = 1; r <= nRises; r++) begin
         pulseClk();
         checkOutput($sformatf("%s_rise%0d", name, r));
      end
      if (nRises >= FRAME) begin
         checkVal({name, "_busy_end"}, 32'(ifc.busy), 32'd0);
         checkVal({name, "_done_count"}, 32'(doneCount - doneBefore), 32'd1);
      end else begin
         checkVal({name, "_busy_mid"}, 32'(ifc.busy), 32'd1);
         checkVal({name, "_done_count"}, 32'(doneCount - doneBefore), 32'd0);
      end
   endtask

   // Drive joystick inputs and run one frame. With sticky capture, a priming
   // load first flushes presses left over from the previous vector.
   task automatic applyStimulus(input logic [11:0] j1, input logic [11:0] j2,
                                input logic [23:0] expFrame, input int nRises, input string name);
      ifc.joystick1 = j1;
      ifc.joystick2 = j2;
`ifdef JOY_STICKY_PRESS_EN
      ifc.JOY_LOAD = 1'b0;
      repeat (4) @(negedge clk_sys);
      ifc.JOY_LOAD = 1'b1;
      repeat (4) @(negedge clk_sys);
`endif
      runLoadedFrame(expFrame, nRises, name);
   endtask

   // Watchdog so the run always ends
   initial begin
      #400000;
      failures++;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence
   initial begin
      int doneBefore;

      vecs[0] = '{12'hFFE, 12'hFFF, 24'hFFFF7F, 8'd24};
      vecs[1] = '{12'hFFF, 12'h7FF, 24'hFDFFFF, 8'd24};
      vecs[2] = '{12'hFFF, 12'hFFF, 24'hFFFFFF, 8'd24};
      vecs[3] = '{12'h000, 12'hFFF, 24'h0FFF00, 8'd24};
      vecs[4] = '{12'hFFF, 12'hEFF, 24'hFFFEFF, 8'd24};
      vecs[5] = '{12'hF7F, 12'hFFF, 24'h7FFFFF, 8'd24};
      vecs[6] = '{12'hFBF, 12'hFFE, 24'hFF7FFD, 8'd24};
      vecs[7] = '{12'hBFF, 12'hDFF, 24'hEBFFFF, 8'd30};

      reset         = 1'b1;
      ifc.JOY_CLK   = 1'b0;
      ifc.JOY_LOAD  = 1'b1;
      ifc.joystick1 = 12'hFFF;
      ifc.joystick2 = 12'hFFF;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      checkVal("reset_data", 32'(ifc.JOY_DATA), 32'd1);
      checkVal("reset_busy", 32'(ifc.busy), 32'd0);
      checkVal("reset_done", 32'(ifc.frame_done), 32'd0);

      // Shift clocks before any load must not start a frame
      for (int i = 0; i < 2; i++) begin
         pulseClk();
         checkVal("preload_data", 32'(ifc.JOY_DATA), 32'd1);
         checkVal("preload_busy", 32'(ifc.busy), 32'd0);
      end
      checkVal("preload_done", 32'(doneCount), 32'd0);

      // Pin-to-data latency for the load strobe and for a shift clock
      ifc.joystick1 = 12'hEFF;
      ifc.JOY_LOAD  = 1'b0;
      measureLatency("load_latency", 1'b0);
      repeat (2) @(negedge clk_sys);
      ifc.JOY_LOAD = 1'b1;
      repeat (4) @(negedge clk_sys);
      checkVal("latency_bit0", 32'(ifc.JOY_DATA), 32'd0);
      ifc.JOY_CLK = 1'b1;
      measureLatency("clk_latency", 1'b1);
      repeat (2) @(negedge clk_sys);
      ifc.JOY_CLK = 1'b0;
      repeat (4) @(negedge clk_sys);

      // Table-driven frames (vector 0: basic frame, 1: order, 7: over-clock)
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].j1, vecs[v].j2, vecs[v].expFrame, int'(vecs[v].nRises),
                       $sformatf("vec%0d", v));
      end

      // Abort after 10 clocks, then a full frame must start from bit 0
      applyStimulus(12'hFBF, 12'hFFE, 24'hFF7FFD, 10, "abort_part");
      applyStimulus(12'hFFE, 12'hFFF, 24'hFFFF7F, 24, "after_abort");

      // Reset at bit 5, then clocks are ignored until a new load
      applyStimulus(12'h000, 12'hFFF, 24'h0FFF00, 5, "pre_reset");
      checkVal("pre_reset_data", 32'(ifc.JOY_DATA), 32'd0);
      doneBefore = doneCount;
      reset = 1'b1;
      @(negedge clk_sys);
      checkVal("in_reset_data", 32'(ifc.JOY_DATA), 32'd1);
      @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      checkVal("post_reset_data", 32'(ifc.JOY_DATA), 32'd1);
      checkVal("post_reset_busy", 32'(ifc.busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         pulseClk();
         checkVal("post_reset_clk_data", 32'(ifc.JOY_DATA), 32'd1);
         checkVal("post_reset_clk_busy", 32'(ifc.busy), 32'd0);
      end
      checkVal("post_reset_done", 32'(doneCount - doneBefore), 32'd0);
      applyStimulus(12'hFFE, 12'hFFF, 24'hFFFF7F, 24, "fresh_after_reset");

`ifdef JOY_STICKY_PRESS_EN
      // Two-cycle tap on joystick1[4] between loads lands at frame index 3
      applyStimulus(12'hFFF, 12'hFFF, 24'hFFFFFF, 24, "sticky_prep");
      ifc.joystick1 = 12'hFEF;
      repeat (2) @(negedge clk_sys);
      ifc.joystick1 = 12'hFFF;
      repeat (4) @(negedge clk_sys);
      runLoadedFrame(24'hFFFFF7, 24, "sticky");
      runLoadedFrame(24'hFFFFFF, 24, "sticky_cleared");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/joy_serializer.md
JOY_SERIALIZER -- requirements
Module: joy_serializer

Interface
REQ-001 Parameter FRAME_BITS, default 24: number of bits shifted per frame.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages on the JOY_CLK and JOY_LOAD pin inputs.
REQ-003 clk_sys  input  1  system clock; JOY_CLK is at least 8x slower.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 joystick1  input  12  player-1 controls, active-low, sampled at load.
REQ-006 joystick2  input  12  player-2 controls, active-low, sampled at load.
REQ-007 JOY_CLK  input  1  shift clock from the reader, asynchronous to clk_sys.
REQ-008 JOY_LOAD  input  1  active-low parallel-load strobe from the reader, asynchronous.
REQ-009 JOY_DATA  output  1  serial data to the reader, registered.
REQ-010 busy  output  1  high from load release until the last bit has been presented.
REQ-011 frame_done  output  1  one-cycle pulse when the final bit has been shifted.

Function
REQ-012 JOY_CLK and JOY_LOAD SHALL each pass through SYNC_STAGES flip-flops; JOY_CLK rising edges SHALL be detected on the synchronized signal.
REQ-013 Frame bit order SHALL be:
- joystick1[8,6,5,4,3,2,1,0]
- joystick2[8,6,5,4,3,2,1,0]
- joystick2[10,11,9,7]
- joystick1[10,11,9,7]
REQ-014 The state machine SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-015 IDLE: JOY_DATA SHALL be 1. Synchronized JOY_LOAD low SHALL move the machine to LOAD.
REQ-016 LOAD: the shift register SHALL reload from the inputs every cycle, JOY_DATA SHALL equal frame bit 0, and the bit count SHALL be 0. Synchronized JOY_LOAD high SHALL move the machine to SHIFT.
REQ-017 SHIFT: each detected JOY_CLK rise SHALL advance one bit and increment the bit count. When the count reaches FRAME_BITS, the machine SHALL move to DONE and pulse frame_done.
REQ-018 DONE: JOY_DATA SHALL be 1 (idle fill). JOY_LOAD low SHALL move the machine to LOAD.
REQ-019 JOY_DATA SHALL change 3 clk_sys cycles after the pin edge (with SYNC_STAGES=2).
REQ-020 A JOY_CLK rise while JOY_LOAD is low SHALL be ignored; load dominates.
REQ-021 JOY_LOAD low in SHIFT SHALL abort the frame without a frame_done pulse and enter LOAD.
REQ-022 Extra JOY_CLK rises in DONE SHALL keep JOY_DATA at 1 and the bit count SHALL not wrap.
REQ-023 busy SHALL be high exactly in SHIFT.

Reset
REQ-024 Reset SHALL set state=IDLE, JOY_DATA=1, busy=0, frame_done=0, bit count=0 and synchronizers=1. This applies mid-frame as well.
REQ-025 After reset, a full frame SHALL be produced only after a fresh JOY_LOAD low.

Configuration
REQ-026 Macro JOY_STICKY_PRESS_EN SHALL select sticky-press capture.
REQ-027 With JOY_STICKY_PRESS_EN defined:
- a 24-bit sticky register SHALL capture any low input between loads;
- the loaded frame SHALL be input AND sticky;
- the sticky register SHALL return to all-1 on the LOAD-to-SHIFT transition.
REQ-028 Without JOY_STICKY_PRESS_EN: no sticky register; the load samples the inputs directly.

Structure
REQ-029 Shared package joy_pkg SHALL hold:
- JOY_FRAME_BITS=24;
- the state enumeration;
- the frame bit-order table (frame index to joystick/bit).
The receiver SHALL use the same table.
REQ-030 Sub-module joy_sync (SYNC_STAGES synchronizer plus rising-edge detect) SHALL be instantiated once each for JOY_CLK and JOY_LOAD.

Verification
REQ-031 The bench SHALL cover:
- Frame: joystick1=12'hFFE, joystick2=12'hFFF, load pulse then 24 clocks -> JOY_DATA sequence 1111_1110 then all 1s; frame_done pulse once.
- Order: joystick2[11]=0, others 1 -> a single 0 at frame index 17.
- Abort: JOY_LOAD low after 10 clocks -> no frame_done; next frame starts at bit 0.
- Over-clock: 30 JOY_CLK rises -> JOY_DATA=1 for rises 24-29; busy=0.
- Reset mid-frame at bit 5 -> JOY_DATA=1, state IDLE; clocks ignored until a new load.
- Sticky (JOY_STICKY_PRESS_EN): joystick1[4] low for 2 cycles between loads -> 0 at frame index 3.
